// File: rtl/mem_req_queue.sv
// mem_req_queue
//   In-order request queue sitting in front of the memory access unit. Buffers
//   load/store requests from execute, issues the head entry over the
//   order/accepted/done handshake (one request in flight at a time) and
//   returns load results tagged with their destination register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      push handshake from execute (ready = not full)
//   req_io/address/data/tag  request fields (io: 1 = store, 0 = load)
//   order                    head entry presented to the memory unit
//   accepted                 memory unit took the head this cycle
//   done                     memory unit finished the in-flight request
//   io/address/i_data        head entry fields towards the memory unit
//   o_data                   load result from the memory unit (done cycle)
//   resp_valid/data/tag      registered one-cycle load completion
//   count                    occupied entries, including the in-flight head
module mem_req_queue #(
  parameter  int DEPTH  = 4,
  parameter  int WORD_W = 32,
  parameter  int TAG_W  = 5,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_io,
  input  logic [WORD_W-1:0] req_address,
  input  logic [WORD_W-1:0] req_data,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              order,
  input  logic              accepted,
  input  logic              done,
  output logic              io,
  output logic [WORD_W-1:0] address,
  output logic [WORD_W-1:0] i_data,
  input  logic [WORD_W-1:0] o_data,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [AW:0]       count
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic              r_io   [DEPTH];
  logic [WORD_W-1:0] r_addr [DEPTH];
  logic [WORD_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0]  r_tag  [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_state;

  logic              r_resp_valid;
  logic [WORD_W-1:0] r_resp_data;
  logic [TAG_W-1:0]  r_resp_tag;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_order;
  logic w_acc;
  logic w_pop;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = req_valid & ~w_full;
  assign w_order = (r_state == S_IDLE) & ~w_empty;
  // accepted without an outstanding order is a protocol error and is ignored
  assign w_acc   = accepted & w_order;
  // done only counts when something is actually in flight (or a store is
  // accepted and completed in the same cycle); stray done in IDLE is ignored
  assign w_pop   = done & ((r_state == S_WAIT) | w_acc);

  assign req_ready  = ~w_full;
  assign order      = w_order;
  assign io         = r_io[r_rd_ptr];
  assign address    = r_addr[r_rd_ptr];
  assign i_data     = r_data[r_rd_ptr];
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_tag   = r_resp_tag;
  assign count      = r_count;

  // entry storage: written on push, never reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_io[r_wr_ptr]   <= req_io;
      r_addr[r_wr_ptr] <= req_address;
      r_data[r_wr_ptr] <= req_data;
      r_tag[r_wr_ptr]  <= req_tag;
    end
  end

  // pointers, occupancy and issue state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_IDLE;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE:  if (w_acc && !done) r_state <= S_WAIT;
        S_WAIT:  if (done)           r_state <= S_IDLE;
        default:                     r_state <= S_IDLE;
      endcase
    end
  end

  // load response register: one-cycle pulse after a completed load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else begin
      r_resp_valid <= w_pop & ~r_io[r_rd_ptr];
      if (w_pop && !r_io[r_rd_ptr]) begin
        r_resp_data <= o_data;
        r_resp_tag  <= r_tag[r_rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_io = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic [4:0]  req_tag = '0;
  logic        order;
  logic        accepted;
  logic        done;
  logic        io;
  logic [31:0] address;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic [2:0]  count;

  mem_req_queue #(.DEPTH(4), .WORD_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_io(req_io),
    .req_address(req_address), .req_data(req_data), .req_tag(req_tag),
    .order(order), .accepted(accepted), .done(done),
    .io(io), .address(address), .i_data(i_data), .o_data(o_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_resp  = 0;
  int st_done = 0;
  int last_resp_cyc = 0;
  int push_cyc = 0;

  logic [36:0] sb[$];           // {tag, data} of expected load responses
  logic [31:0] sh_mem[64];      // bench view of memory in push order
  logic [31:0] mu_mem[64];      // memory unit contents

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory unit model: accepts whenever enabled, store done same cycle,
  // load done two cycles after accept
  logic mu_en = 1'b1;
  logic mu_busy = 1'b0;
  logic [1:0] mu_cnt = '0;
  assign accepted = mu_en & order & ~mu_busy;
  assign done     = (accepted & io) | (mu_busy & (mu_cnt == 2'd0));
  assign o_data   = mu_mem[address[7:2]];

  always @(posedge clk) begin
    if (rst) begin
      mu_busy <= 1'b0;
      mu_cnt  <= '0;
    end else begin
      if (accepted && !io) begin
        mu_busy <= 1'b1;
        mu_cnt  <= 2'd1;
      end else if (mu_busy) begin
        if (mu_cnt == 2'd0) mu_busy <= 1'b0;
        else                mu_cnt  <= mu_cnt - 2'd1;
      end
      if (done && io) begin
        mu_mem[address[7:2]] <= i_data;
        st_done <= st_done + 1;
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      n_resp++;
      last_resp_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("resp_unexpected", 64'd1, 64'd0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        check_eq("resp_tag", 64'(resp_tag), 64'(e[36:32]));
        check_eq("resp_data", 64'(resp_data), 64'(e[31:0]));
      end
    end
  end

  task automatic push(input logic io_i, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] t, output int waited);
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      check_eq("push_timeout", 64'd0, 64'd1);
      return;
    end
    req_valid = 1'b1; req_io = io_i; req_address = a; req_data = d; req_tag = t;
    push_cyc = cyc;
    if (io_i) sh_mem[a[7:2]] = d;
    else      sb.push_back({t, sh_mem[a[7:2]]});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int k;
    k = 0;
    while (n_resp < target && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("resp_arrived", 64'(n_resp >= target), 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (count != 3'd0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check_eq("idle_count", 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < 64; i++) begin
      sh_mem[i] = 32'hC0DE0000 | 32'(i);
      mu_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    sh_mem[4] = 32'hDEADBEEF;
    mu_mem[4] = 32'hDEADBEEF;

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_order", 64'(order), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);

    // single load with latency check
    push(1'b0, 32'h10, 32'h0, 5'd7, w);
    check_eq("t2_order", 64'(order), 64'd1);
    check_eq("t2_count", 64'(count), 64'd1);
    wait_resp(1);
    check_eq("t2_latency", 64'(last_resp_cyc - push_cyc), 64'd4);
    check_eq("t2_count_end", 64'(count), 64'd0);

    // four back-to-back stores
    wait_idle();
    begin
      int s0;
      int wsum;
      s0 = st_done;
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
        push(1'b1, 32'h80 + 32'(i * 4), 32'hA000 + 32'(i), 5'd0, w);
        wsum += w;
      end
      check_eq("t3_no_stall", 64'(wsum), 64'd0);
      @(posedge clk); #1;
      check_eq("t3_stores_done", 64'(st_done - s0), 64'd4);
      check_eq("t3_count", 64'(count), 64'd0);
    end

    // fill with four loads, fifth waits for the first pop
    wait_idle();
    mu_en = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 32'h40 + 32'(i * 4), 32'h0, 5'(10 + i), w);
    check_eq("t4_full_count", 64'(count), 64'd4);
    check_eq("t4_full_ready", 64'(req_ready), 64'd0);
    mu_en = 1'b1;
    push(1'b0, 32'h50, 32'h0, 5'd14, w);
    check_eq("t4_wait_cycles", 64'(w), 64'd3);
    wait_resp(6);

    // store then load of the same address
    wait_idle();
    push(1'b1, 32'h20, 32'h12345678, 5'd0, w);
    push(1'b0, 32'h20, 32'h0, 5'd3, w);
    wait_resp(7);
    check_eq("t5_mem_written", 64'(mu_mem[8]), 64'h12345678);

    // reset while a load is in flight with three entries queued
    wait_idle();
    mu_en = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 32'h60 + 32'(i * 4), 32'h0, 5'(20 + i), w);
    check_eq("t6_count_pre", 64'(count), 64'd3);
    mu_en = 1'b1;
    @(posedge clk); #1;
    mu_en = 1'b0;
    check_eq("t6_wait_order", 64'(order), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_eq("t6_count", 64'(count), 64'd0);
    check_eq("t6_order", 64'(order), 64'd0);
    check_eq("t6_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("t6_req_ready", 64'(req_ready), 64'd1);
    repeat (4) begin @(posedge clk); #1; end
    check_eq("t6_no_resp", 64'(n_resp), 64'd7);

    // recovery after reset
    mu_en = 1'b1;
    push(1'b0, 32'h10, 32'h0, 5'd9, w);
    wait_resp(8);
    wait_idle();
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    check_eq("n_resp_total", 64'(n_resp), 64'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
